apb_master_bridge: RTL and testbench

Single-outstanding APB master that converts a valid/ready command stream into APB3 transfers and returns each result on a valid/ready response stream. It sits directly upstream of the APB bus signal bundle and drives PSEL/PENABLE/PWRITE/PADDR/PWDATA into slaves. It consumes PRDATA/PREADY/PSLVERR. It also enforces a PREADY timeout so that a hung slave cannot stall the system.

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB3 master with PREADY timeout
// Converts a valid/ready command into one APB transfer and returns the result on a response stream.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    // cmd_ready is registered so it stays low while reset is held and rises one edge later.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // Completion has priority over a timeout firing in the same cycle.
                    if (PREADY) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= RESP;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int tests = 0;
    int fails = 0;
    int pe_cnt;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        PRESET = 1'b0;
        #1;
        chk("rel_cmd_ready_before_edge", cmd_ready, 0);
        step();
        chk("rel_cmd_ready_after_edge", cmd_ready, 1);

        PRDATA = 32'hFFFF0000;
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_cmd_ready", cmd_ready, 0);
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_paddr", PADDR, 32'h10);
        chk("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
        PREADY = 1'b1;
        step();
        chk("wr_access_psel", PSEL, 1);
        chk("wr_access_penable", PENABLE, 1);
        step();
        PREADY = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_psel", PSEL, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_done_rsp_valid", rsp_valid, 0);
        chk("wr_done_cmd_ready", cmd_ready, 1);

        PRDATA = '0;
        issue(1'b0, 32'h20, 32'h0);
        chk("rd_setup_penable", PENABLE, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd_access_penable", PENABLE, 1);
            chk("rd_access_paddr", PADDR, 32'h20);
            chk("rd_access_rsp_valid", rsp_valid, 0);
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'h12345678;
            end
        end
        step();
        PREADY = 1'b0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_rsp_timeout_loses", rsp_timeout, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        issue(1'b1, 32'h30, 32'h55);
        step();
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        step();
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_err", rsp_err, 1);
            chk("bp_rsp_rdata", rsp_rdata, 0);
            chk("bp_rsp_timeout", rsp_timeout, 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_done_cmd_ready", cmd_ready, 1);

        PRDATA = 32'hA5A5A5A5;
        issue(1'b0, 32'h40, 32'h0);
        pe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid) break;
            if (PENABLE) pe_cnt++;
        end
        chk("to_penable_cycles", pe_cnt, 4);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_psel", PSEL, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        issue(1'b1, 32'h50, 32'h99);
        step();
        chk("mr_access_penable", PENABLE, 1);
        #1;
        PRESET = 1'b1;
        PREADY = 1'b1;
        #1;
        chk("mr_psel_async", PSEL, 0);
        chk("mr_penable_async", PENABLE, 0);
        step();
        step();
        chk("mr_no_rsp", rsp_valid, 0);
        PRESET = 1'b0;
        PREADY = 1'b0;
        step();
        chk("mr_cmd_ready", cmd_ready, 1);
        issue(1'b1, 32'h60, 32'h77);
        PREADY = 1'b1;
        step();
        step();
        PREADY = 1'b0;
        chk("mr_next_rsp_valid", rsp_valid, 1);
        chk("mr_next_rsp_err", rsp_err, 0);
        chk("mr_next_paddr", PADDR, 32'h60);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("mr_next_cmd_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
